// File: rtl/uart_deserialize.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, 8N1 frames or 8E1 frames
// when built with `define UART_PARITY_EN.
module uart_deserialize #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_serialized,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
`endif
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          rx_s;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic          framing_error_q, framing_error_d;
  logic          bit_end;
`ifdef UART_PARITY_EN
  logic          par_bit_q, par_bit_d;
  logic          parity_error_q, parity_error_d;
`endif

  assign rx_s    = sync2_q;
  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    sync1_d         = rx_serialized;
    sync2_d         = sync1_q;
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    data_d          = data_q;
    data_valid_d    = 1'b0;
    framing_error_d = framing_error_q;
`ifdef UART_PARITY_EN
    par_bit_d       = par_bit_q;
    parity_error_d  = parity_error_q;
`endif

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      // Half a bit in: confirms a real start bit and aligns later samples to mid-bit.
      START: begin
        if (cnt_q == CNT_MID) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d     = '0;
          par_bit_d = rx_s;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif

      // Frame is delivered with its flags regardless of errors; a low stop bit
      // parks in WAIT_IDLE so a break yields exactly one frame.
      STOP: begin
        if (bit_end) begin
          cnt_d           = '0;
          data_d          = shift_q;
          data_valid_d    = 1'b1;
          framing_error_d = ~rx_s;
`ifdef UART_PARITY_EN
          parity_error_d  = ^{shift_q, par_bit_q};
`endif
          state_d         = rx_s ? IDLE : WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      state_q         <= IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      data_q          <= 8'h00;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit_q       <= 1'b0;
      parity_error_q  <= 1'b0;
`endif
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      data_q          <= data_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
`ifdef UART_PARITY_EN
      par_bit_q       <= par_bit_d;
      parity_error_q  <= parity_error_d;
`endif
    end
  end

  assign data          = data_q;
  assign data_valid    = data_valid_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != IDLE);
`ifdef UART_PARITY_EN
  assign parity_error  = parity_error_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_deserialize.sv
// Scoreboard bench for uart_deserialize; adapts frame format to UART_PARITY_EN.
module tb_uart_deserialize;

  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int EXP_LAT = 2 + CPB / 2 + (NBITS - 1) * CPB + 1;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx_serialized;
  logic [7:0] data;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_pulse  = 0;
  int   cyc      = 0;
  int   t_start  = 0;
  int   t_dv     = 0;
  logic dv_prev  = 1'b0;

  uart_deserialize #(.CLKS_PER_BIT(CPB)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx_serialized (rx_serialized),
    .data          (data),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected frame per data_valid pulse.
  always @(negedge clock) begin
    if (data_valid) begin
      exp_t e;
      n_pulse++;
      t_dv = cyc;
      chk("dv_single_cycle", {31'd0, dv_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got data %0h expected no pulse", data);
      end else begin
        e = exp_q.pop_front();
        chk("data", {24'd0, data}, {24'd0, e.d});
        chk("parity_error", {31'd0, parity_error}, {31'd0, e.pe});
        chk("framing_error", {31'd0, framing_error}, {31'd0, e.fe});
      end
    end
    dv_prev <= data_valid;
  end

  task automatic send_bit(input logic b);
    rx_serialized = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    exp_t e;
    e.d = d;
`ifdef UART_PARITY_EN
    e.pe = (^d) ^ par;
`else
    e.pe = 1'b0;
`endif
    e.fe = ~stop;
    exp_q.push_back(e);
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  initial begin
    reset_n       = 1'b0;
    rx_serialized = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_data", {24'd0, data}, 32'h00);
    chk("rst_dv", {31'd0, data_valid}, 32'd0);
    chk("rst_pe", {31'd0, parity_error}, 32'd0);
    chk("rst_fe", {31'd0, framing_error}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // Clean frame, plus latency from start edge to data_valid.
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("latency_ok", {31'd0, ((t_dv - t_start) >= EXP_LAT - 1) && ((t_dv - t_start) <= EXP_LAT + 1)}, 32'd1);
    repeat (20) @(negedge clock);
    chk("pulses_a5", n_pulse, 1);
    chk("hold_data", {24'd0, data}, 32'hA5);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Odd data with parity bit 0.
    send_frame(8'h01, 1'b0, 1'b1);
    repeat (10) @(negedge clock);
    chk("pulses_01", n_pulse, 2);
    chk("hold_data_01", {24'd0, data}, 32'h01);

    // Break: stop bit low and line held low 40 bit periods in total.
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (20 * CPB) @(negedge clock);
    chk("break_busy", {31'd0, busy}, 32'd1);
    repeat (19 * CPB) @(negedge clock);
    chk("break_busy_end", {31'd0, busy}, 32'd1);
    chk("break_hold_fe", {31'd0, framing_error}, 32'd1);
    rx_serialized = 1'b1;
    repeat (6) @(negedge clock);
    chk("break_busy_release", {31'd0, busy}, 32'd0);
    chk("pulses_break", n_pulse, 3);

    // 6-clock low glitch.
    repeat (2 * CPB) @(negedge clock);
    rx_serialized = 1'b0;
    repeat (6) @(negedge clock);
    chk("glitch_busy", {31'd0, busy}, 32'd1);
    rx_serialized = 1'b1;
    repeat (10) @(negedge clock);
    chk("glitch_busy_drop", {31'd0, busy}, 32'd0);
    repeat (2 * CPB) @(negedge clock);
    chk("pulses_glitch", n_pulse, 3);
    chk("glitch_hold_data", {24'd0, data}, 32'h3C);

    // Back-to-back frames, then reset at mid-bit 4 of a third frame.
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h12 >> i));
    rx_serialized = 1'b0;
    repeat (CPB / 2) @(negedge clock);
    chk("pulses_b2b", n_pulse, 5);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_data", {24'd0, data}, 32'h00);
    chk("mid_rst_dv", {31'd0, data_valid}, 32'd0);
    chk("mid_rst_fe", {31'd0, framing_error}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clock);
    rx_serialized = 1'b1;
    reset_n = 1'b1;
    repeat (2 * NBITS * CPB) @(negedge clock);
    chk("pulses_after_rst", n_pulse, 5);
    chk("post_rst_pe", {31'd0, parity_error}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
